bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
Read-side client of the true dual-port BRAM. It drives one BRAM port to fetch a contiguous address range and presents the words as a valid/ready stream, for example to feed spike or weight words to the neuron update pipeline. It hides the BRAM's one-cycle registered read latency. A 2-entry output buffer sustains one word per cycle under continuous ready and never loses data under backpressure.

Parameters:
DATA_WIDTH, 16, BRAM word width and out_data width
ADDR_WIDTH, 10, BRAM address width; BRAM depth = 2**ADDR_WIDTH

Ports:
clock  input  1  single clock for all logic and the attached BRAM port
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a transfer; ignored while busy
base_addr  input  ADDR_WIDTH  first address, sampled when start is accepted
length  input  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH, sampled with start
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at transfer end
bram_en  output  1  BRAM port enable
bram_we  output  1  BRAM write enable, constant 0
bram_addr  output  ADDR_WIDTH  BRAM port address
bram_din  output  DATA_WIDTH  BRAM write data, constant 0
bram_dout  input  DATA_WIDTH  BRAM read data, valid the cycle after bram_en
out_valid  output  1  out_data/out_last valid
out_ready  input  1  downstream accepts the word
out_data  output  DATA_WIDTH  streamed word
out_last  output  1  marks the final word of the transfer

Behaviour:
- Reset values: busy=0, done=0, bram_en=0, bram_addr=0, out_valid=0, out_data=0, out_last=0. Reset also empties the buffer, clears the in-flight flag and puts the FSM in IDLE.
- Reset mid-transfer aborts the transfer: buffered and in-flight words are discarded and no done pulse is generated.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: start=1 latches base_addr and length. If length≠0, go to RUN; if length=0, go to FIN.
  - RUN: issues reads. After the last read is issued, go to DRAIN.
  - DRAIN: when the last word handshakes (out_valid&&out_ready&&out_last), go to FIN.
  - FIN: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in RUN, DRAIN and FIN; otherwise 0. A start asserted while busy=1 is ignored. start in the same cycle as FIN's done is also ignored, because it is sampled only in IDLE.
- Read issue (combinational):
  - issue = (state==RUN) && (count + inflight − pop < 2).
  - count is buffer occupancy (0..2); inflight is a register set on the cycle after issue; pop = out_valid&&out_ready.
  - bram_en = issue; bram_addr = current read address.
  - Read address starts at base_addr and increments by 1 per issue, modulo 2**ADDR_WIDTH (wraps from 2**ADDR_WIDTH−1 to 0).
  - Remaining-word counter decrements per issue. The issue that takes it to 0 moves the FSM to DRAIN.
- Data return: when inflight=1, bram_dout is written into the buffer that cycle. The word tagged as the last read carries out_last=1. The issue rule guarantees the buffer never overflows.
- Output: out_valid = count≠0; out_data/out_last come from the head entry. Push and pop may occur in the same cycle. Data must hold stable while out_valid=1 and out_ready=0.
- Latency: start in cycle 0 → bram_en cycle 1 → bram_dout cycle 2 → out_valid cycle 3.
- Throughput: with out_ready held at 1, one word per cycle. Total for N words: the last word is accepted in cycle N+2 and done pulses in cycle N+3.
- length=2**ADDR_WIDTH reads every address exactly once, wrapping if base_addr≠0.

Test Plan:
- Preload mem[i]=i+0x100; start with base=4, length=5, out_ready=1 → bram_en cycles 1–5 with addr 4..8; out_data 0x104..0x108 on cycles 3–7; out_last only on 0x108; done pulses in cycle 8.
- length=0 → no bram_en, no out_valid; busy=1 and done=1 in cycle 1 only.
- base=1022, length=4, ADDR_WIDTH=10 → addresses 1022, 1023, 0, 1 in order; data matches those locations.
- length=8 with out_ready toggling 1,0,0,1,… → stream is in order with no drop or duplicate; out_data holds stable while stalled; issue stops whenever buffer plus in-flight reaches 2.
- start pulsed again mid-transfer with different base/length → ignored; the original 8 words complete.
- reset asserted in cycle 4 of a length-10 transfer → next cycle all outputs are at reset values and no done pulse occurs; a new start then runs cleanly from IDLE.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Streams a contiguous BRAM address range out as a valid/ready word stream.
// A 2-entry buffer absorbs the one-cycle BRAM read latency so the stream
// sustains one word per cycle and never drops data under backpressure.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; base_addr/length latched on start
// RUN   | issuing reads while buffer + in-flight words stay below 2
// DRAIN | all reads issued; waiting for the last word to handshake
// FIN   | one-cycle done pulse, then back to IDLE
module bram_stream_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_din,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH:0]   remain;
   logic                  inflight;
   logic                  inflight_last;

   // Buffer entries carry {last, data}
   logic [DATA_WIDTH:0]   fifo_mem [2];
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [1:0]            count;

   logic                  issue;
   logic                  pop;
   logic                  push;

   // Read issue: keep buffered plus in-flight words (net of this cycle's pop) below 2
   always_comb begin
      pop   = out_valid && out_ready;
      push  = inflight;
      issue = (state == RUN) &&
              (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
   end

   assign bram_en   = issue;
   assign bram_we   = 1'b0;
   assign bram_addr = rd_addr;
   assign bram_din  = '0;

   assign out_valid = (count != 2'd0);
   assign out_data  = fifo_mem[rd_ptr][DATA_WIDTH-1:0];
   assign out_last  = fifo_mem[rd_ptr][DATA_WIDTH];

   // Sequencing FSM with registered busy/done, read address and remaining count
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_addr <= '0;
         remain  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rd_addr <= base_addr;
                  remain  <= length;
                  busy    <= 1'b1;
                  if (length == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  rd_addr <= rd_addr + ADDR_WIDTH'(1);
                  remain  <= remain - (ADDR_WIDTH+1)'(1);
                  if (remain == (ADDR_WIDTH+1)'(1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && out_last) begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // In-flight flag: a read issued this cycle returns data next cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_last <= issue && (remain == (ADDR_WIDTH+1)'(1));
      end
   end

   // Output buffer: push returned BRAM data, pop on handshake, both allowed together
   always_ff @(posedge clock) begin
      if (reset) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {inflight_last, bram_dout};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model, per-cycle behavioural reference
// of the expected stream, plus literal checks for the key scenarios.
module tb_bram_stream_reader;

   localparam int DW    = 16;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy, done, bram_en, bram_we, out_valid, out_last;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_din, out_data;
   logic [DW-1:0] bram_dout = '0;
   logic          out_ready = 1'b1;

   logic [DW-1:0] mem [DEPTH];

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int hs_total   = 0;
   int ready_mode = 0;
   int pat_idx    = 0;
   bit mon_en     = 1'b0;

   bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .length(length), .busy(busy), .done(done), .bram_en(bram_en),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .bram_dout(bram_dout), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   always #5 clock = ~clock;

   // BRAM port with one-cycle registered read
   always @(posedge clock) begin
      if (bram_en) bram_dout <= mem[bram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a transfer is a list of words mem[base+i]; word i becomes
   // visible two cycles after its read issues, and a read may issue only while
   // fewer than two words are outstanding (net of this cycle's acceptance).
   bit m_active = 1'b0, m_fin = 1'b0, was_idle;
   int m_base = 0, m_len = 0, m_issued = 0, m_acc = 0;
   int issue_cyc [$];
   bit e_valid, e_en, e_pop, e_last;
   logic [DW-1:0] e_data;
   logic [AW-1:0] e_addr;

   always @(negedge clock) begin
      cyc++;
      e_valid = m_active && !m_fin && (m_acc < m_issued) && (issue_cyc[m_acc] <= cyc - 2);
      e_data  = mem[(m_base + m_acc) % DEPTH];
      e_last  = (m_acc == m_len - 1);
      e_pop   = e_valid && out_ready;
      e_en    = m_active && !m_fin && (m_issued < m_len) &&
                ((m_issued - m_acc - int'(e_pop)) < 2);
      e_addr  = AW'((m_base + m_issued) % DEPTH);
      if (mon_en) begin
         chk("busy", busy, m_active);
         chk("done", done, m_active && m_fin);
         chk("bram_en", bram_en, e_en);
         if (e_en) chk("bram_addr", bram_addr, e_addr);
         chk("bram_we", bram_we, 0);
         chk("bram_din", bram_din, 0);
         chk("out_valid", out_valid, e_valid);
         if (e_valid) begin
            chk("out_data", out_data, e_data);
            chk("out_last", out_last, e_last);
         end
      end
      if (out_valid && out_ready) hs_total++;
      was_idle = !m_active;
      if (reset) begin
         m_active = 0; m_fin = 0; m_issued = 0; m_acc = 0;
         issue_cyc.delete();
      end else begin
         if (m_active) begin
            if (m_fin) begin
               m_active = 0; m_fin = 0;
            end else begin
               if (e_en) begin issue_cyc.push_back(cyc); m_issued++; end
               if (e_pop) begin
                  m_acc++;
                  if (m_acc == m_len) m_fin = 1;
               end
            end
         end
         if (was_idle && start) begin
            m_active = 1; m_base = int'(base_addr); m_len = int'(length);
            m_issued = 0; m_acc = 0; m_fin = (length == 0);
            issue_cyc.delete();
         end
      end
   end

   // Advance one cycle; inputs change #1 after the edge
   task automatic tick();
      @(posedge clock);
      #1;
      start = 1'b0;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom_range(0, 1) == 1);
         default: begin
            out_ready = (pat_idx % 3 == 0);
            pat_idx++;
         end
      endcase
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_start(input int b, input int l);
      tick();
      start     = 1'b1;
      base_addr = AW'(b);
      length    = (AW+1)'(l);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      tick();
      while (busy && k < budget) begin
         tick();
         k++;
      end
      if (busy) chk("xfer_timeout", busy, 0);
   endtask

   initial begin
      int hs0;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h100);
      ticks(3);
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", bram_en, 0);
      chk("rst_addr", bram_addr, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);

      // base 4, length 5, continuous ready
      do_start(4, 5);
      tick(); @(negedge clock);
      chk("t1_c1_en", bram_en, 1);
      chk("t1_c1_addr", bram_addr, 4);
      ticks(2); @(negedge clock);
      chk("t1_c3_valid", out_valid, 1);
      chk("t1_c3_data", out_data, 'h104);
      chk("t1_c3_last", out_last, 0);
      ticks(4); @(negedge clock);
      chk("t1_c7_data", out_data, 'h108);
      chk("t1_c7_last", out_last, 1);
      tick(); @(negedge clock);
      chk("t1_c8_done", done, 1);
      tick(); @(negedge clock);
      chk("t1_c9_busy", busy, 0);

      // zero length
      do_start(7, 0);
      tick(); @(negedge clock);
      chk("len0_busy", busy, 1);
      chk("len0_done", done, 1);
      chk("len0_en", bram_en, 0);
      chk("len0_valid", out_valid, 0);
      tick(); @(negedge clock);
      chk("len0_busy2", busy, 0);
      chk("len0_done2", done, 0);

      // address wrap
      do_start(1022, 4);
      ticks(3); @(negedge clock);
      chk("wrap_en", bram_en, 1);
      chk("wrap_addr", bram_addr, 0);
      ticks(2); @(negedge clock);
      chk("wrap_data", out_data, 'h100);
      wait_idle(100);

      // backpressure pattern plus ignored mid-transfer start
      hs0 = hs_total;
      ready_mode = 2; pat_idx = 0;
      do_start(40, 8);
      ticks(3);
      start = 1'b1; base_addr = AW'(300); length = (AW+1)'(3);
      wait_idle(200);
      ready_mode = 0;
      chk("stall_words", hs_total - hs0, 8);

      // reset mid-transfer
      do_start(20, 10);
      ticks(4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("rst2_busy", busy, 0);
      chk("rst2_done", done, 0);
      chk("rst2_en", bram_en, 0);
      chk("rst2_addr", bram_addr, 0);
      chk("rst2_valid", out_valid, 0);
      chk("rst2_data", out_data, 0);
      chk("rst2_last", out_last, 0);
      ticks(3);
      do_start(50, 3);
      wait_idle(100);

      // randomized transfers over random memory contents
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      ready_mode = 1;
      for (int t = 0; t < 30; t++) begin
         int l;
         if (t == 5) l = DEPTH;
         else if (t == 6) l = 1;
         else l = $urandom_range(0, 24);
         do_start($urandom_range(0, DEPTH - 1), l);
         if ($urandom_range(0, 3) == 0) begin
            tick();
            start = 1'b1; base_addr = AW'($urandom); length = (AW+1)'($urandom_range(1, 9));
         end
         wait_idle(6000);
         ticks($urandom_range(0, 2));
      end
      ready_mode = 0;
      ticks(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
